// File: rtl/stream_mux_arb.sv
// rtl/stream_mux_arb.sv - N:1 valid/ready stream mux with fixed-select or round-robin grant and one registered output stage
module stream_mux_arb #(
    parameter  int N     = 4,
    parameter  int W     = 32,
    localparam int SEL_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N-1:0]     in_valid,
    output logic [N-1:0]     in_ready,
    input  logic [N*W-1:0]   in_data,
    input  logic             mode_rr,
    input  logic [SEL_W-1:0] sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_data,
    output logic [SEL_W-1:0] out_src
);

    // Round-robin pointer: the most recently granted channel in rr mode.
    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] grant;
    logic             grant_valid;
    logic             load;
    logic             transfer;
    int               sel_int;
    int               idx;

    // The output stage can take a beat when empty or when its beat drains this cycle.
    assign load = !out_valid || out_ready;

    // Grant selection. In rr mode the search walks from the farthest channel
    // back to ptr+1, so the last hit written is the nearest one after ptr;
    // ptr itself is covered at distance N, i.e. with lowest priority.
    always_comb begin
        grant_valid = 1'b0;
        grant       = '0;
        sel_int     = int'(sel);
        idx         = 0;
        if (!mode_rr) begin
            if (sel_int < N) begin
                grant_valid = 1'b1;
                grant       = sel;
            end
        end else begin
            for (int k = N; k >= 1; k--) begin
                idx = (int'(ptr) + k) % N;
                if (in_valid[idx]) begin
                    grant_valid = 1'b1;
                    grant       = SEL_W'(idx);
                end
            end
        end
    end

    // Only the granted channel sees ready, and only while the output stage can load.
    // Held low during reset so no beat is reported accepted while registers are cleared.
    always_comb begin
        in_ready = '0;
        if (reset_n && grant_valid && load) begin
            in_ready[grant] = 1'b1;
        end
    end

    assign transfer = grant_valid && in_valid[grant] && load;

    // Output register and rr pointer update; a new beat replaces a draining one with no bubble.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
            ptr       <= SEL_W'(N - 1);
        end else begin
            if (transfer) begin
                out_valid <= 1'b1;
                out_data  <= in_data[int'(grant)*W +: W];
                out_src   <= grant;
                if (mode_rr) begin
                    ptr <= grant;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_stream_mux_arb.sv
// tb/tb_stream_mux_arb.sv - self-checking bench for stream_mux_arb against a behavioural model
module tb_stream_mux_arb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset_n;

    logic [3:0]   iv;
    wire  [3:0]   ir;
    logic [127:0] id;
    logic         mrr;
    logic [1:0]   sel;
    wire          ov;
    logic         ordy;
    wire  [31:0]  od;
    wire  [1:0]   os;

    logic [5:0]   iv6;
    wire  [5:0]   ir6;
    logic [95:0]  id6;
    logic [2:0]   sel6;
    wire          ov6;
    logic         ordy6;
    wire  [15:0]  od6;
    wire  [2:0]   os6;

    stream_mux_arb #(.N(4), .W(32)) dut4 (
        .clk(clk), .reset_n(reset_n), .in_valid(iv), .in_ready(ir), .in_data(id),
        .mode_rr(mrr), .sel(sel), .out_valid(ov), .out_ready(ordy),
        .out_data(od), .out_src(os)
    );

    stream_mux_arb #(.N(6), .W(16)) dut6 (
        .clk(clk), .reset_n(reset_n), .in_valid(iv6), .in_ready(ir6), .in_data(id6),
        .mode_rr(1'b0), .sel(sel6), .out_valid(ov6), .out_ready(ordy6),
        .out_data(od6), .out_src(os6)
    );

    int passed = 0;
    int total  = 0;

    // reference model state for the N=4 instance
    bit          m_valid;
    logic [31:0] m_data;
    int          m_src;
    int          m_ptr;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        total++;
        assert (obs === exp_v) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    endtask

    task automatic model_reset();
        m_valid = 0;
        m_data  = 32'h0;
        m_src   = 0;
        m_ptr   = 3;
    endtask

    // Grant from the rules: fixed index, or first valid channel after the pointer.
    function automatic int exp_grant();
        if (!mrr) return (int'(sel) < 4) ? int'(sel) : -1;
        for (int k = 1; k <= 4; k++) begin
            int c;
            c = (m_ptr + k) % 4;
            if (iv[c]) return c;
        end
        return -1;
    endfunction

    // Check combinational and registered outputs, clock once, advance the model.
    task automatic step(input string tag);
        int         g;
        bit         ld;
        logic [3:0] exp_ir;
        #1;
        g      = exp_grant();
        ld     = !m_valid || ordy;
        exp_ir = (g >= 0 && ld) ? (4'b0001 << g) : 4'b0000;
        chk({tag, ".in_ready"},  {60'h0, ir}, {60'h0, exp_ir});
        chk({tag, ".out_valid"}, {63'h0, ov}, {63'h0, m_valid});
        chk({tag, ".out_data"},  {32'h0, od}, {32'h0, m_data});
        chk({tag, ".out_src"},   {62'h0, os}, 64'(m_src));
        @(posedge clk);
        if (g >= 0 && ld && iv[g]) begin
            m_valid = 1;
            m_data  = id[g*32 +: 32];
            m_src   = g;
            if (mrr) m_ptr = g;
        end else if (m_valid && ordy) begin
            m_valid = 0;
        end
        #1;
    endtask

    initial begin
        logic [31:0] held_d;
        logic [1:0]  held_s;

        reset_n = 0; iv = '0; id = '0; mrr = 0; sel = 0; ordy = 1;
        iv6 = '0; id6 = '0; sel6 = 0; ordy6 = 1;
        model_reset();

        // 1: reset held with random inputs
        for (int i = 0; i < 3; i++) begin
            iv = 4'($urandom); id = {$urandom, $urandom, $urandom, $urandom};
            mrr = 1'($urandom); sel = 2'($urandom); ordy = 1'($urandom);
            @(posedge clk); #1;
            chk("rst.out_valid", {63'h0, ov}, 64'h0);
            chk("rst.out_data",  {32'h0, od}, 64'h0);
            chk("rst.out_src",   {62'h0, os}, 64'h0);
            chk("rst.in_ready",  {60'h0, ir}, 64'h0);
        end
        reset_n = 1;

        // 2: fixed select sel=2
        mrr = 0; sel = 2; iv = 4'b1111; ordy = 1;
        id = {32'h3333_3333, 32'hDEAD_BEEF, 32'h1111_1111, 32'h0000_0000};
        #1 chk("fix.in_ready", {60'h0, ir}, 64'h4);
        step("fix");
        chk("fix.data_after", {32'h0, od}, 64'hDEAD_BEEF);
        chk("fix.src_after",  {62'h0, os}, 64'h2);

        // 3: round-robin from reset pointer, all valid
        mrr = 1;
        for (int i = 0; i < 6; i++) begin
            id = {$urandom, $urandom, $urandom, $urandom};
            step("rr");
            chk("rr.src_seq", {62'h0, os}, 64'(i % 4));
        end

        // 4: stall for 5 cycles with changing inputs
        ordy = 0;
        step("stall.enter");
        held_d = od; held_s = os;
        for (int i = 0; i < 5; i++) begin
            iv = 4'($urandom); id = {$urandom, $urandom, $urandom, $urandom};
            mrr = 1'($urandom); sel = 2'($urandom);
            #1 chk("stall.in_ready", {60'h0, ir}, 64'h0);
            step("stall");
            chk("stall.data_hold", {32'h0, od}, {32'h0, held_d});
            chk("stall.src_hold",  {62'h0, os}, {62'h0, held_s});
        end
        mrr = 1; iv = 4'b1111; ordy = 1;
        step("unstall");
        chk("unstall.no_bubble", {63'h0, ov}, 64'h1);
        chk("unstall.next_src",  {62'h0, os}, 64'((int'(held_s) + 1) % 4));

        // randomized traffic against the model
        for (int i = 0; i < 300; i++) begin
            iv   = 4'($urandom);
            id   = {$urandom, $urandom, $urandom, $urandom};
            mrr  = 1'($urandom);
            sel  = 2'($urandom);
            ordy = ($urandom_range(0, 3) != 0);
            step("rand");
        end

        // 5: N=6 fixed-mode boundary
        iv6 = 6'b111111; ordy6 = 1;
        for (int c = 0; c < 6; c++) id6[c*16 +: 16] = 16'(16'hA000 + c);
        sel6 = 5;
        #1 chk("b6.in_ready_sel5", {58'h0, ir6}, 64'h20);
        @(posedge clk); #1;
        chk("b6.out_valid", {63'h0, ov6}, 64'h1);
        chk("b6.out_src",   {61'h0, os6}, 64'h5);
        chk("b6.out_data",  {48'h0, od6}, 64'hA005);
        sel6 = 6;
        #1 chk("b6.in_ready_sel6", {58'h0, ir6}, 64'h0);
        @(posedge clk); #1;
        chk("b6.drain",     {63'h0, ov6}, 64'h0);
        chk("b6.data_keep", {48'h0, od6}, 64'hA005);
        sel6 = 7;
        #1 chk("b6.in_ready_sel7", {58'h0, ir6}, 64'h0);

        // 6: async reset mid-stall, then rr restarts at channel 0
        mrr = 1; iv = 4'b1111; ordy = 1;
        id = {$urandom, $urandom, $urandom, $urandom};
        step("pre_rst");
        ordy = 0;
        step("pre_rst.stall");
        chk("pre_rst.valid", {63'h0, ov}, 64'h1);
        reset_n = 0;
        #1 chk("arst.out_valid_now", {63'h0, ov}, 64'h0);
        model_reset();
        @(posedge clk); #1;
        reset_n = 1;
        mrr = 1; iv = 4'b1111; ordy = 1;
        step("post_rst");
        chk("post_rst.first_src", {62'h0, os}, 64'h0);
        step("post_rst2");
        chk("post_rst.second_src", {62'h0, os}, 64'h1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
